// File: rtl/decode_writeback.sv
// Y86-64 decode/writeback stage: specifier decode, register-file read with
// E/M/W forwarding, W-stage writeback and the E pipeline register.
module decode_writeback #(
  parameter logic [3:0] RNONE    = 4'hF,
  parameter logic [3:0] RRSP     = 4'h4,
  parameter logic [3:0] STAT_AOK = 4'b1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  D_stat,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  D_ifun,
  input  logic [3:0]  D_rA,
  input  logic [3:0]  D_rB,
  input  logic [63:0] D_valC,
  input  logic [63:0] D_valP,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstE,
  input  logic [63:0] M_valE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] m_valM,
  input  logic [3:0]  W_dstE,
  input  logic [63:0] W_valE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valM,
  input  logic        E_bubble,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [3:0]  E_stat,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [63:0] E_valC,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB
);

  localparam logic [3:0] INOP = 4'h1;

  logic [63:0] rf_reg [0:14];
  logic [3:0]  src_a, src_b, dst_e, dst_m;
  logic [63:0] rd_a, rd_b, val_a, val_b;

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (D_icode)
      4'h2: begin src_a = D_rA; dst_e = D_rB; end
      4'h3: dst_e = D_rB;
      4'h4: begin src_a = D_rA; src_b = D_rB; end
      4'h5: begin src_b = D_rB; dst_m = D_rA; end
      4'h6: begin src_a = D_rA; src_b = D_rB; dst_e = D_rB; end
      4'h8: begin src_b = RRSP; dst_e = RRSP; end
      4'h9: begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; end
      4'hA: begin src_a = D_rA; src_b = RRSP; dst_e = RRSP; end
      4'hB: begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; dst_m = D_rA; end
      default: ;
    endcase
  end

  assign d_srcA = src_a;
  assign d_srcB = src_b;

  // Reads see the pre-write array; same-cycle writes reach us via W forwarding.
  assign rd_a = (src_a == RNONE) ? 64'd0 : rf_reg[src_a];
  assign rd_b = (src_b == RNONE) ? 64'd0 : rf_reg[src_b];

  function automatic logic [63:0] forward(input logic [3:0] src, input logic [63:0] rd);
    logic [63:0] v;
    v = rd;
    if (src != RNONE) begin
      if      (src == e_dstE) v = e_valE;
      else if (src == M_dstM) v = m_valM;
      else if (src == M_dstE) v = M_valE;
      else if (src == W_dstM) v = W_valM;
      else if (src == W_dstE) v = W_valE;
    end
    return v;
  endfunction

  always_comb begin
    val_a = forward(src_a, rd_a);
    if (D_icode == 4'h7 || D_icode == 4'h8) val_a = D_valP;
    val_b = forward(src_b, rd_b);
  end

  // M port is checked first so it wins when both ports hit one register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) rf_reg[i] <= 64'd0;
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (W_dstM == 4'(i))      rf_reg[i] <= W_valM;
        else if (W_dstE == 4'(i)) rf_reg[i] <= W_valE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      E_stat  <= STAT_AOK;
      E_icode <= INOP;
      E_ifun  <= 4'h0;
      E_valC  <= 64'd0;
      E_valA  <= 64'd0;
      E_valB  <= 64'd0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else if (E_bubble) begin
      E_stat  <= STAT_AOK;
      E_icode <= INOP;
      E_ifun  <= 4'h0;
      E_valC  <= 64'd0;
      E_valA  <= 64'd0;
      E_valB  <= 64'd0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else begin
      E_stat  <= D_stat;
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_valC  <= D_valC;
      E_valA  <= val_a;
      E_valB  <= val_b;
      E_dstE  <= dst_e;
      E_dstM  <= dst_m;
      E_srcA  <= src_a;
      E_srcB  <= src_b;
    end
  end

endmodule

// File: tb/tb_decode_writeback.sv
// Bench for decode_writeback: directed cases from the stage's rules plus
// randomized traffic checked each cycle against a behavioural model.
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic        E_bubble;
  logic [3:0]  d_srcA, d_srcB, E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;

  decode_writeback dut (
    .clk(clk), .rst_n(rst_n),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE),
    .W_dstM(W_dstM), .W_valM(W_valM), .E_bubble(E_bubble),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_stat(E_stat), .E_icode(E_icode),
    .E_ifun(E_ifun), .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  stat, icode, ifun, dste, dstm, srca, srcb;
    logic [63:0] valc, vala, valb;
  } e_t;

  int checks = 0;
  int failures = 0;
  int txn = 0;
  bit chk_en = 1'b0;
  logic [63:0] model_rf [15];
  e_t exp_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (txn %0d)", name, act, req, txn);
    end
  endtask

  // Specifier tables, stated as instruction-class membership.
  function automatic logic [3:0] m_srca(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction
  function automatic logic [3:0] m_srcb(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction
  function automatic logic [3:0] m_dste(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction
  function automatic logic [3:0] m_dstm(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h5, 4'hB}) return ra;
    return 4'hF;
  endfunction

  // Operand value: ordered list of (destination, value) sources, first hit wins.
  function automatic logic [63:0] m_operand(input logic [3:0] src);
    logic [3:0]  fd [5];
    logic [63:0] fv [5];
    if (src == 4'hF) return 64'd0;
    fd = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    fv = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    for (int k = 0; k < 5; k++)
      if (fd[k] == src) return fv[k];
    return model_rf[src];
  endfunction

  function automatic e_t nop_e();
    e_t n;
    n.stat = 4'b1000; n.icode = 4'h1; n.ifun = 4'h0;
    n.dste = 4'hF; n.dstm = 4'hF; n.srca = 4'hF; n.srcb = 4'hF;
    n.valc = '0; n.vala = '0; n.valb = '0;
    return n;
  endfunction

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("E_stat",  E_stat,  exp_q.stat);
      chk("E_icode", E_icode, exp_q.icode);
      chk("E_ifun",  E_ifun,  exp_q.ifun);
      chk("E_valC",  E_valC,  exp_q.valc);
      chk("E_valA",  E_valA,  exp_q.vala);
      chk("E_valB",  E_valB,  exp_q.valb);
      chk("E_dstE",  E_dstE,  exp_q.dste);
      chk("E_dstM",  E_dstM,  exp_q.dstm);
      chk("E_srcA",  E_srcA,  exp_q.srca);
      chk("E_srcB",  E_srcB,  exp_q.srcb);
      chk("d_srcA",  d_srcA,  m_srca(D_icode, D_rA));
      chk("d_srcB",  d_srcB,  m_srcb(D_icode, D_rB));
    end
  end

  task automatic idle();
    D_stat = 4'b1000; D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF;
    D_valC = '0; D_valP = '0;
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
    E_bubble = 1'b0;
  endtask

  // One clock: model the edge from current inputs, then settle past the next negedge.
  task automatic step();
    e_t n;
    if (E_bubble) n = nop_e();
    else begin
      n.stat = D_stat; n.icode = D_icode; n.ifun = D_ifun; n.valc = D_valC;
      n.srca = m_srca(D_icode, D_rA); n.srcb = m_srcb(D_icode, D_rB);
      n.dste = m_dste(D_icode, D_rB); n.dstm = m_dstm(D_icode, D_rA);
      n.vala = (D_icode == 4'h7 || D_icode == 4'h8) ? D_valP : m_operand(n.srca);
      n.valb = m_operand(n.srcb);
    end
    $display("txn %0d icode=%h rA=%h rB=%h bubble=%b Wdst=%h/%h", txn, D_icode, D_rA, D_rB,
             E_bubble, W_dstE, W_dstM);
    @(posedge clk);
    exp_q = n;
    if (W_dstE != 4'hF) model_rf[W_dstE] = W_valE;
    if (W_dstM != 4'hF) model_rf[W_dstM] = W_valM;
    @(negedge clk);
    #1;
    txn++;
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst E_icode", E_icode, 64'h1);
    chk("rst E_dstE",  E_dstE,  64'hF);
    chk("rst E_valA",  E_valA,  64'h0);
    chk("rst E_stat",  E_stat,  64'h8);
    for (int i = 0; i < 15; i++) model_rf[i] = '0;
    exp_q = nop_e();
    idle();
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [3:0] rand_reg();
    return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 6));
  endfunction

  initial begin
    for (int i = 0; i < 15; i++) model_rf[i] = '0;
    exp_q = nop_e();
    idle();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Mid-operation reset clears the register file.
    idle(); W_dstE = 4'h3; W_valE = 64'h99; step();
    mid_reset();
    idle(); D_icode = 4'h2; D_rA = 4'h3; D_rB = 4'h7; step();
    chk("post-reset read", E_valA, 64'h0);

    // Writeback then read.
    idle(); W_dstE = 4'h3; W_valE = 64'h55; step();
    idle(); D_icode = 4'h2; D_rA = 4'h3; D_rB = 4'h7; step();
    chk("wb read valA", E_valA, 64'h55);
    chk("wb read dstE", E_dstE, 64'h7);
    chk("wb read srcB", E_srcB, 64'hF);

    // Forwarding priority.
    idle(); D_icode = 4'h6; D_rA = 4'h2; D_rB = 4'h2;
    e_dstE = 4'h2; e_valE = 64'd11; M_dstE = 4'h2; M_valE = 64'd22; W_dstE = 4'h2; W_valE = 64'd33;
    step();
    chk("fwd e valA", E_valA, 64'd11);
    chk("fwd e valB", E_valB, 64'd11);
    e_dstE = 4'hF; step();
    chk("fwd M valA", E_valA, 64'd22);

    // popq with both write ports on %rsp.
    idle(); D_icode = 4'hB; D_rA = 4'h4; D_rB = 4'hF;
    W_dstE = 4'h4; W_valE = 64'h100; W_dstM = 4'h4; W_valM = 64'h200;
    #1;
    chk("popq d_srcA", d_srcA, 64'h4);
    chk("popq d_srcB", d_srcB, 64'h4);
    step();
    chk("popq valA", E_valA, 64'h200);
    chk("popq dstM", E_dstM, 64'h4);
    idle(); D_icode = 4'h2; D_rA = 4'h4; D_rB = 4'h0; step();
    chk("popq rf", E_valA, 64'h200);

    // call uses valP for valA and %rsp for valB.
    idle(); W_dstE = 4'h4; W_valE = 64'h80; step();
    idle(); D_icode = 4'h8; D_valP = 64'h40; step();
    chk("call valA", E_valA, 64'h40);
    chk("call valB", E_valB, 64'h80);
    chk("call dstE", E_dstE, 64'h4);

    // Bubble still commits writeback.
    idle(); E_bubble = 1'b1; D_icode = 4'h3; D_valC = 64'd9; D_rB = 4'h1;
    W_dstE = 4'h1; W_valE = 64'h77; step();
    chk("bubble icode", E_icode, 64'h1);
    chk("bubble valC", E_valC, 64'h0);
    chk("bubble dstE", E_dstE, 64'hF);
    chk("bubble stat", E_stat, 64'h8);
    idle(); D_icode = 4'h2; D_rA = 4'h1; step();
    chk("bubble wb", E_valA, 64'h77);

    // Invalid opcode passes status through with no specifiers.
    idle(); D_icode = 4'hC; D_stat = 4'h3; D_rA = 4'h1; D_rB = 4'h2; step();
    chk("inv stat", E_stat, 64'h3);
    chk("inv dstE", E_dstE, 64'hF);
    chk("inv srcA", E_srcA, 64'hF);

    for (int c = 0; c < 600; c++) begin
      if (c == 300) mid_reset();
      D_stat = 4'($urandom); D_icode = 4'($urandom_range(0, 15)); D_ifun = 4'($urandom);
      D_rA = rand_reg(); D_rB = rand_reg();
      D_valC = {$urandom, $urandom}; D_valP = {$urandom, $urandom};
      e_dstE = rand_reg(); M_dstE = rand_reg(); M_dstM = rand_reg();
      W_dstE = rand_reg(); W_dstM = rand_reg();
      e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom}; m_valM = {$urandom, $urandom};
      W_valE = {$urandom, $urandom}; W_valM = {$urandom, $urandom};
      E_bubble = ($urandom_range(0, 9) == 0);
      step();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_writeback.md
Name: decode_writeback

Overview:
- Y86-64 pipeline decode stage. Sits directly downstream of the fetch stage and consumes its D_* pipeline-register outputs.
- Decodes register specifiers and reads the 15-entry register file, with data forwarding from the E/M/W stages.
- Performs register-file writeback from the W stage.
- Drives the E_* pipeline register consumed by execute.

Parameters:
- RNONE, 4'hF, "no register" specifier
- RRSP, 4'h4, stack-pointer register index
- STAT_AOK, 4'b1000, status value loaded on bubble/reset

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- D_stat  in  4  decode-stage status
- D_icode  in  4  decode-stage opcode
- D_ifun  in  4  decode-stage function code
- D_rA  in  4  register specifier A
- D_rB  in  4  register specifier B
- D_valC  in  64  constant word
- D_valP  in  64  incremented PC
- e_dstE  in  4  execute destination, current cycle
- e_valE  in  64  execute ALU result, current cycle
- M_dstE  in  4  memory-stage E destination
- M_valE  in  64  memory-stage E value
- M_dstM  in  4  memory-stage M destination
- m_valM  in  64  memory read data, current cycle
- W_dstE  in  4  writeback E destination
- W_valE  in  64  writeback E value
- W_dstM  in  4  writeback M destination
- W_valM  in  64  writeback M value
- E_bubble  in  1  load bubble into E register
- d_srcA  out  4  combinational srcA, to hazard control
- d_srcB  out  4  combinational srcB, to hazard control
- E_stat  out  4  registered status
- E_icode  out  4  registered opcode
- E_ifun  out  4  registered function code
- E_valC  out  64  registered constant
- E_valA  out  64  registered operand A
- E_valB  out  64  registered operand B
- E_dstE  out  4  registered E destination
- E_dstM  out  4  registered M destination
- E_srcA  out  4  registered source A
- E_srcB  out  4  registered source B

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0), effective immediately and mid-operation:
  - E_icode=1 (nop), E_ifun=0, E_stat=STAT_AOK.
  - E_valC, E_valA, E_valB = 0.
  - E_dstE, E_dstM, E_srcA, E_srcB = RNONE.
  - All 15 registers cleared to 0.
- Opcode decode (combinational on D_icode):
  - srcA: rA for 2, 4, 6, A; RRSP for 9, B; else RNONE.
  - srcB: rB for 4, 5, 6; RRSP for 8, 9, A, B; else RNONE.
  - dstE: rB for 2, 3, 6; RRSP for 8, 9, A, B; else RNONE. cmov condition is resolved in execute, not here.
  - dstM: rA for 5, B; else RNONE.
- Register read: combinational from the array. Index RNONE reads 0.
- valA selection, first match wins:
  - icode 7 or 8 -> D_valP
  - srcA==e_dstE -> e_valE
  - srcA==M_dstM -> m_valM
  - srcA==M_dstE -> M_valE
  - srcA==W_dstM -> W_valM
  - srcA==W_dstE -> W_valE
  - else register read.
  - Forwarding never matches when the source is RNONE.
- valB selection: same priority chain without the valP term.
- Writeback on posedge clk:
  - W_dstE!=RNONE writes W_valE.
  - W_dstM!=RNONE writes W_valM.
  - If both target the same register, W_valM wins (popq %rsp).
  - A read of the register being written in the same cycle returns the old array value; the W forwarding paths supply the new value.
- E register on posedge clk:
  - E_bubble=1 loads the reset bubble values; register-file writes still occur.
  - Otherwise loads D_stat, D_icode, D_ifun, D_valC, the selected valA/valB, dstE, dstM, srcA and srcB.
- Latency: D inputs appear on E outputs one clock later.
- Invalid icodes (C-F): decoded as RNONE on all four specifiers, and stat passes through unchanged.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> E_icode=1, E_dstE=F, E_valA=0 immediately. Release, then read any register via rrmovq -> 0.
- Writeback then read: W_dstE=3, W_valE=0x55 for one edge; next cycle D rrmovq rA=3 rB=7, no forwarding -> E_valA=0x55, E_dstE=7, E_srcB=F.
- Forward priority: D OPq rA=2 rB=2 with e_dstE=2/e_valE=11, M_dstE=2/M_valE=22, W_dstE=2/W_valE=33 -> E_valA=E_valB=11. Drop e_dstE to F -> 22.
- popq conflict: W_dstE=4/W_valE=0x100 and W_dstM=4/W_valM=0x200 on same edge -> register 4 reads 0x200. Same cycle, D popq -> d_srcA=d_srcB=4, E_valA=0x200 via W_dstM forward.
- call: D_icode=8, D_valP=0x40, register 4 holds 0x80 -> E_valA=0x40, E_valB=0x80, E_dstE=4.
- Bubble: E_bubble=1 with D irmovq valC=9 rB=1 -> E_icode=1, E_valC=0, E_dstE=F, E_stat=1000. A concurrent W write to register 1 is still committed.
